// File: rtl/dr_pkg.sv
// ----------------------------------------------------------------------------
// dr_pkg
// Shared definitions for the dual-rail gate stage: operation encoding,
// channel codewords ({t,f} pairs) and the per-channel evaluation and
// illegal-codeword helpers used by dr_gate_stage.
// ----------------------------------------------------------------------------
package dr_pkg;

   typedef enum logic [1:0] {
      DR_AND = 2'b00,
      DR_OR  = 2'b01,
      DR_NOT = 2'b10,
      DR_XOR = 2'b11
   } dr_op_e;

   // Channel codewords, written as {t, f}.
   localparam logic [1:0] DR_SPACER  = 2'b00;
   localparam logic [1:0] DR_ONE     = 2'b10;
   localparam logic [1:0] DR_ZERO    = 2'b01;
   localparam logic [1:0] DR_ILLEGAL = 2'b11;

   // Strict dual-rail evaluation of one channel. A spacer on any operand the
   // operation actually uses forces a spacer result; B is unused for NOT.
   function automatic logic [1:0] dr_eval(input dr_op_e op,
                                          input logic at, input logic af,
                                          input logic bt, input logic bf);
      logic [1:0] res;
      logic       spacer_in;
      res       = DR_SPACER;
      spacer_in = ({at, af} == DR_SPACER) ||
                  ((op != DR_NOT) && ({bt, bf} == DR_SPACER));
      case (op)
         DR_AND: res = {at & bt, af | bf};
         DR_OR:  res = {at | bt, af & bf};
         DR_NOT: res = {af, at};
         DR_XOR: res = {(at & bf) | (af & bt), (at & bt) | (af & bf)};
         default: res = DR_SPACER;
      endcase
      if (spacer_in) res = DR_SPACER;
      return res;
   endfunction

   // True when a used operand channel carries the illegal 11 codeword.
   function automatic logic dr_illegal(input dr_op_e op,
                                       input logic [1:0] a,
                                       input logic [1:0] b);
      return (a == DR_ILLEGAL) || ((op != DR_NOT) && (b == DR_ILLEGAL));
   endfunction

endpackage

// File: rtl/dr_fifo.sv
// ----------------------------------------------------------------------------
// dr_fifo
// Synchronous FIFO with first-word-fall-through output (dout is the head).
// Push on a full FIFO and pop on an empty FIFO are ignored.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, din       write request and data
//   pop             read request (advances head)
//   dout            current head entry
//   count           occupancy, 0..DEPTH
//   full, empty     occupancy flags
// ----------------------------------------------------------------------------
module dr_fifo #(
   parameter int DW    = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [DW-1:0]              din,
   input  logic                       pop,
   output logic [DW-1:0]              dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // NOTE: the storage array is reset along with the pointers so the head
   // reads as spacer (all zero) straight out of reset; it is only DEPTH words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dr_gate_stage.sv
// ----------------------------------------------------------------------------
// dr_gate_stage
// Configurable dual-rail logic stage: captures a beat (operands + op) into
// S1, evaluates it the following cycle, drops beats containing illegal 11
// codewords (pulsing err_illegal and bumping a saturating counter), and
// queues legal results in an output FIFO.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   a_t/a_f, b_t/b_f      operand rails, WIDTH channels each
//   op                    00 AND, 01 OR, 10 NOT(A), 11 XOR
//   in_valid/in_ready     input handshake
//   q_t/q_f               result rails (FIFO head)
//   out_valid/out_ready   output handshake
//   err_illegal           one-cycle pulse when a beat is dropped
//   err_count             saturating drop counter
//   clr_err               synchronous clear of err_count
// ----------------------------------------------------------------------------
module dr_gate_stage
   import dr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a_t,
   input  logic [WIDTH-1:0] a_f,
   input  logic [WIDTH-1:0] b_t,
   input  logic [WIDTH-1:0] b_f,
   input  logic [1:0]       op,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] q_t,
   output logic [WIDTH-1:0] q_f,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             err_illegal,
   output logic [CNT_W-1:0] err_count,
   input  logic             clr_err
);

   localparam int                AW      = $clog2(DEPTH);
   localparam logic [CNT_W-1:0]  ERR_MAX = '1;

   // Stage-1 register.
   logic             s1_valid;
   dr_op_e           s1_op;
   logic [WIDTH-1:0] s1_at, s1_af, s1_bt, s1_bf;

   logic [WIDTH-1:0] res_t, res_f;
   logic             s1_bad;
   logic             accept;
   logic             fifo_push;
   logic             fifo_full;
   logic             fifo_empty;
   logic [AW:0]      fifo_count;
   logic [AW+1:0]    occupancy;

   // Occupancy counts the beat in S1 as already committed to the FIFO, so S1
   // can always push the cycle after capture. Built from registers only; the
   // rst_n term holds in_ready low while reset is asserted.
   assign occupancy = {1'b0, fifo_count} + (AW+2)'(s1_valid);
   assign in_ready  = rst_n & (occupancy < (AW+2)'(DEPTH));
   assign accept    = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= DR_AND;
         s1_at    <= '0;
         s1_af    <= '0;
         s1_bt    <= '0;
         s1_bf    <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_op <= dr_op_e'(op);
            s1_at <= a_t;
            s1_af <= a_f;
            s1_bt <= b_t;
            s1_bf <= b_f;
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      res_t  = '0;
      res_f  = '0;
      s1_bad = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         {res_t[i], res_f[i]} = dr_eval(s1_op, s1_at[i], s1_af[i], s1_bt[i], s1_bf[i]);
         s1_bad = s1_bad | dr_illegal(s1_op, {s1_at[i], s1_af[i]}, {s1_bt[i], s1_bf[i]});
      end
   end

   assign err_illegal = s1_valid & s1_bad;
   // The full term never blocks in practice: in_ready reserves a slot for S1.
   assign fifo_push   = s1_valid & ~s1_bad & ~fifo_full;

   // A drop coinciding with clr_err leaves the count at 1, not 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (clr_err) begin
         err_count <= err_illegal ? CNT_W'(1) : '0;
      end else if (err_illegal && (err_count != ERR_MAX)) begin
         err_count <= err_count + 1'b1;
      end
   end

   dr_fifo #(
      .DW    (2*WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .din   ({res_t, res_f}),
      .pop   (out_ready),
      .dout  ({q_t, q_f}),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_valid = ~fifo_empty;

endmodule

// File: tb/tb_dr_gate_stage.sv
// ----------------------------------------------------------------------------
// tb_dr_gate_stage
// Self-checking bench for dr_gate_stage (WIDTH=8, DEPTH=4, CNT_W=2).
// A value-level reference model (decode channels to 0/1/spacer, apply the
// Boolean operator, re-encode) runs in lock-step with every clock edge;
// hand-computed vector tables and sequences cover the listed corner cases.
// ----------------------------------------------------------------------------
module tb_dr_gate_stage;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CNT_W = 2;
   localparam int ERR_MAX = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] a_t, a_f, b_t, b_f;
   logic [1:0]       op;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] q_t, q_f;
   logic             out_valid;
   logic             out_ready;
   logic             err_illegal;
   logic [CNT_W-1:0] err_count;
   logic             clr_err;

   dr_gate_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a_t         (a_t),
      .a_f         (a_f),
      .b_t         (b_t),
      .b_f         (b_f),
      .op          (op),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .q_t         (q_t),
      .q_f         (q_f),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .err_illegal (err_illegal),
      .err_count   (err_count),
      .clr_err     (clr_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] op;
      logic [7:0] at, af, bt, bf;
   } beat_t;

   typedef struct {
      string      name;
      logic [1:0] op;
      logic [7:0] at, af, bt, bf;
      bit         drop;
      logic [7:0] qt, qf;
   } vec_t;

   // Reference model state.
   logic [15:0] mq[$];
   bit          m_s1_v = 0;
   beat_t       m_s1;
   int          m_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Value-level model: each channel decodes to logic 0/1 or spacer/illegal.
   function automatic void m_eval(input beat_t b, output bit drop, output logic [15:0] r);
      logic [7:0] t, f;
      bit         use_b;
      bit         va, vb, v;
      t = '0;
      f = '0;
      drop = 0;
      use_b = (b.op != 2'd2);
      for (int i = 0; i < 8; i++) begin
         if ({b.at[i], b.af[i]} == 2'b11 || (use_b && {b.bt[i], b.bf[i]} == 2'b11)) drop = 1;
         if ({b.at[i], b.af[i]} == 2'b00 || (use_b && {b.bt[i], b.bf[i]} == 2'b00)) begin
            t[i] = 1'b0;
            f[i] = 1'b0;
         end else begin
            va = b.at[i];
            vb = b.bt[i];
            case (b.op)
               2'd0:    v = va && vb;
               2'd1:    v = va || vb;
               2'd2:    v = !va;
               default: v = va ^ vb;
            endcase
            t[i] = v;
            f[i] = !v;
         end
      end
      r = {t, f};
   endfunction

   task automatic check_outputs();
      bit          d;
      logic [15:0] r;
      check("in_ready", 32'(in_ready), 32'((mq.size() + int'(m_s1_v)) < DEPTH));
      check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) check("q_head", 32'({q_t, q_f}), 32'(mq[0]));
      check("err_count", 32'(err_count), 32'(m_err));
      d = 0;
      if (m_s1_v) m_eval(m_s1, d, r);
      check("err_illegal", 32'(err_illegal), 32'(m_s1_v && d));
   endtask

   // One clock edge: advance the model with the inputs seen at the edge,
   // then compare shortly after.
   task automatic tick();
      bit          rdy, acc, d;
      logic [15:0] r;
      beat_t       cur;
      @(posedge clk);
      cur = '{op: op, at: a_t, af: a_f, bt: b_t, bf: b_f};
      rdy = (mq.size() + int'(m_s1_v)) < DEPTH;
      acc = in_valid && rdy;
      if (out_ready && mq.size() > 0) void'(mq.pop_front());
      d = 0;
      if (m_s1_v) begin
         m_eval(m_s1, d, r);
         if (!d) mq.push_back(r);
      end
      if (clr_err) m_err = (m_s1_v && d) ? 1 : 0;
      else if (m_s1_v && d && m_err < ERR_MAX) m_err++;
      m_s1_v = acc;
      if (acc) m_s1 = cur;
      #1;
      check_outputs();
   endtask

   task automatic drive(input logic [1:0] o, input logic [7:0] at, input logic [7:0] af,
                        input logic [7:0] bt, input logic [7:0] bf, input logic v);
      op = o; a_t = at; a_f = af; b_t = bt; b_f = bf; in_valid = v;
   endtask

   task automatic rand_rails(output logic [7:0] t, output logic [7:0] f);
      int r;
      for (int i = 0; i < 8; i++) begin
         r = $urandom_range(0, 39);
         if (r == 0)      {t[i], f[i]} = 2'b11;
         else if (r < 3)  {t[i], f[i]} = 2'b00;
         else begin
            t[i] = 1'($urandom_range(0, 1));
            f[i] = ~t[i];
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t  vecs[7];
      int    acc_n;
      logic [7:0] rt, rf, rbt, rbf;

      vecs[0] = '{"and_basic", 2'd0, 8'hF0, 8'h0F, 8'h3C, 8'hC3, 0, 8'h30, 8'hCF};
      vecs[1] = '{"xor_basic", 2'd3, 8'hAA, 8'h55, 8'hFF, 8'h00, 0, 8'h55, 8'hAA};
      vecs[2] = '{"not_b_ill", 2'd2, 8'hAA, 8'h55, 8'hFF, 8'hFF, 0, 8'h55, 8'hAA};
      vecs[3] = '{"or_spacer", 2'd1, 8'hF0, 8'h07, 8'h0F, 8'hF0, 0, 8'hF7, 8'h00};
      vecs[4] = '{"and_b_ill", 2'd0, 8'hFF, 8'h00, 8'h2F, 8'hF0, 1, 8'h00, 8'h00};
      vecs[5] = '{"not_b_spc", 2'd2, 8'h0F, 8'hF0, 8'h00, 8'h00, 0, 8'hF0, 8'h0F};
      vecs[6] = '{"not_a_ill", 2'd2, 8'h80, 8'hFF, 8'h00, 8'h00, 1, 8'h00, 8'h00};

      // Reset state.
      rst_n = 1'b0;
      drive(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
      out_ready = 1'b0;
      clr_err = 1'b0;
      #3;
      check("rst_in_ready", 32'(in_ready), 32'(0));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_q", 32'({q_t, q_f}), 32'(0));
      check("rst_err_count", 32'(err_count), 32'(0));
      check("rst_err_illegal", 32'(err_illegal), 32'(0));
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      check("rel_in_ready", 32'(in_ready), 32'(1));
      check("rel_out_valid", 32'(out_valid), 32'(0));

      // Vector table: one isolated beat each, out_ready=1.
      out_ready = 1'b1;
      for (int v = 0; v < 7; v++) begin
         drive(vecs[v].op, vecs[v].at, vecs[v].af, vecs[v].bt, vecs[v].bf, 1'b1);
         tick();
         in_valid = 1'b0;
         check({vecs[v].name, "_err_illegal"}, 32'(err_illegal), 32'(vecs[v].drop));
         check({vecs[v].name, "_valid_early"}, 32'(out_valid), 32'(0));
         tick();
         check({vecs[v].name, "_out_valid"}, 32'(out_valid), 32'(!vecs[v].drop));
         if (!vecs[v].drop) check({vecs[v].name, "_q"}, 32'({q_t, q_f}), 32'({vecs[v].qt, vecs[v].qf}));
         tick();
         check({vecs[v].name, "_one_cycle"}, 32'(out_valid), 32'(0));
      end

      // Back-pressure: 10 beats offered with out_ready=0.
      out_ready = 1'b0;
      acc_n = 0;
      for (int i = 0; i < 10; i++) begin
         drive(2'd2, 8'(i), ~8'(i), 8'h00, 8'h00, 1'b1);
         if (in_ready) acc_n++;
         tick();
      end
      check("fill_accepted", 32'(acc_n), 32'(DEPTH));
      check("fill_in_ready", 32'(in_ready), 32'(0));
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("recover_in_ready", 32'(in_ready), 32'(1));
      repeat (5) tick();
      check("drained", 32'(out_valid), 32'(0));

      // Saturation: 5 illegal beats, then clr_err coinciding with a 6th drop.
      for (int i = 0; i < 5; i++) begin
         drive(2'd0, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b1);
         tick();
      end
      in_valid = 1'b0;
      tick();
      check("err_saturated", 32'(err_count), 32'(ERR_MAX));
      drive(2'd3, 8'h00, 8'hFF, 8'h10, 8'hF0, 1'b1);
      tick();
      in_valid = 1'b0;
      clr_err = 1'b1;
      check("clr_coinc_pulse", 32'(err_illegal), 32'(1));
      tick();
      clr_err = 1'b0;
      check("clr_coinc_count", 32'(err_count), 32'(1));
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      check("clr_plain", 32'(err_count), 32'(0));

      // Reset mid-stream with 3 beats buffered.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(2'd1, 8'h0F, 8'hF0, 8'h00, 8'hFF, 1'b1);
         tick();
      end
      drive(2'd0, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      check("pre_rst_err", 32'(err_count), 32'(1));
      #1 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'(0));
      check("midrst_in_ready", 32'(in_ready), 32'(0));
      check("midrst_err_count", 32'(err_count), 32'(0));
      mq.delete();
      m_s1_v = 0;
      m_err = 0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      check("post_rst_out_valid", 32'(out_valid), 32'(0));
      check("post_rst_in_ready", 32'(in_ready), 32'(1));
      repeat (3) tick();

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rand_rails(rt, rf);
         rand_rails(rbt, rbf);
         drive(2'($urandom_range(0, 3)), rt, rf, rbt, rbf, 1'($urandom_range(0, 3) != 0));
         out_ready = 1'($urandom_range(0, 2) != 0);
         clr_err = 1'($urandom_range(0, 30) == 0);
         tick();
      end
      in_valid = 1'b0;
      clr_err = 1'b0;
      out_ready = 1'b1;
      repeat (8) tick();
      check("final_empty", 32'(out_valid), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
